dotprod_acc: RTL

DOTPROD_ACC -- requirements
Module: dotprod_acc

---
 rtl/dotprod_acc_pkg.sv | 23 ++
 rtl/dotprod_acc_sat_add.sv | 32 +++
 rtl/dotprod_acc.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dotprod_acc_pkg.sv
// Shared types and constant helpers for the dot-product frame accumulator.
package dotprod_acc_pkg;

  // Two-state frame controller: collect samples, then hold the frame sum.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Widest accumulator the bound helpers can describe.
  localparam int unsigned MAX_ACC_W = 64;

  // Largest value of a signed acc_w-bit number: 2^(acc_w-1) - 1.
  function automatic logic signed [MAX_ACC_W-1:0] sat_max(input int unsigned acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  // Smallest value of a signed acc_w-bit number: -2^(acc_w-1).
  function automatic logic signed [MAX_ACC_W-1:0] sat_min(input int unsigned acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/dotprod_acc_sat_add.sv
// Combinational signed saturating adder. An overflow clamps the sum to the
// representable range and raises ovf.
module sat_add
  import dotprod_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 8
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic signed [ACC_W:0] full;

  // One guard bit: overflow exactly when the guard and sign bits disagree.
  always_comb begin
    full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    ovf  = full[ACC_W] ^ full[ACC_W-1];
    if (!ovf) begin
      sum = full[ACC_W-1:0];
    end else if (full[ACC_W]) begin
      sum = SAT_MIN;
    end else begin
      sum = SAT_MAX;
    end
  end

endmodule

// File: rtl/dotprod_acc.sv
// Sums FRAME_LEN signed dot-product results per frame with saturation and
// presents each frame sum behind a valid/ready handshake. Draining a frame
// and accepting the first sample of the next happen in the same cycle.
module dotprod_acc
  import dotprod_acc_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned IN_W      = 4,
  parameter int unsigned ACC_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int unsigned    CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t                  state;
  state_t                  next_state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic                    sat;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic                    accept;
  logic                    last;

  assign in_ext = {{(ACC_W - IN_W){in_data[IN_W-1]}}, in_data};
  assign accept = in_valid && in_ready;
  assign last   = (count == LAST);

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (acc),
    .b   (in_ext),
    .sum (sum),
    .ovf (ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs; while holding, input readiness
  // follows downstream readiness so a drain can overlap the next fill.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    next_state = state;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        if (accept && last) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          next_state = ACCUM;
        end
      end
      default: next_state = ACCUM;
    endcase
  end

  // Accumulator, sample count, sticky saturation and the held frame result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      sat      <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last) begin
              // Publish the frame and clear the running state so HOLD
              // only has to load a possible overlapping first sample.
              out_data <= sum;
              out_sat  <= sat | ovf;
              acc      <= '0;
              count    <= '0;
              sat      <= 1'b0;
            end else begin
              acc   <= sum;
              count <= count + CNT_W'(1);
              sat   <= sat | ovf;
            end
          end
        end
        HOLD: begin
          if (accept) begin
            acc   <= in_ext;
            count <= CNT_W'(1);
            sat   <= 1'b0;
          end
        end
        default: begin
          acc   <= '0;
          count <= '0;
          sat   <= 1'b0;
        end
      endcase
    end
  end

endmodule
